bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameters: none; the digit count (5) and output width (17) SHALL be fixed.
REQ-002 CLOCK_50  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset; sampled only on CLOCK_50 rising edge.
REQ-004 START  input  1  conversion request; level-sampled each edge.
REQ-005 BCD0  input  4  BCD units digit.
REQ-006 BCD1  input  4  BCD tens digit.
REQ-007 BCD2  input  4  BCD hundreds digit.
REQ-008 BCD3  input  4  BCD thousands digit.
REQ-009 BCD4  input  4  BCD ten-thousands digit.
REQ-010 BIN  output  17  unsigned binary result, range 0..99999.
REQ-011 BUSY  output  1  high while a conversion is in progress, including the DONE cycle.
REQ-012 DONE  output  1  single-cycle completion pulse.
REQ-013 ERR  output  1  high when the last completed conversion had an invalid digit.

Function
REQ-014 FSM states SHALL be IDLE, CONV, FIN; BUSY SHALL equal (state != IDLE).
REQ-015 In IDLE with START=1 at edge k: capture BCD4..BCD0 into an internal register, clear accumulator to 0, set digit index to 4, latch invalid flag = (any captured digit > 9), and go to CONV.
REQ-016 Inputs after the capture edge SHALL NOT affect the result.
REQ-017 In CONV, each edge: acc <= acc*10 + digit[index], with index running 4,3,2,1,0; multiply SHALL be implemented as (acc<<3)+(acc<<1), with no multiplier primitive.
REQ-018 The accumulator SHALL be 17 bits; no overflow is possible for valid digits (max 99999 = 0x1869F).
REQ-019 At the CONV edge processing index 0, go to FIN, load BIN with the final value (or 0 if invalid flag set), and set ERR to the invalid flag.
REQ-020 In FIN, DONE SHALL be 1 for exactly one cycle; the next edge returns to IDLE.
REQ-021 Latency: DONE SHALL be high in the cycle after edge k+5 (6 cycles from START sample to DONE), identical for valid and invalid inputs.
REQ-022 BIN and ERR SHALL hold their values from FIN until the next FIN or reset; they SHALL NOT change during CONV.
REQ-023 START while state != IDLE SHALL be ignored (no restart, no queueing).
REQ-024 START held high continuously SHALL start a new conversion on the first edge in IDLE, giving one DONE every 7 cycles.
REQ-025 Invalid digit (10..15) in any position: ERR=1, BIN=0 at completion; DONE timing unchanged.

Reset
REQ-026 RESET=1 at an edge SHALL force IDLE with BIN=0, DONE=0, BUSY=0, ERR=0, and clear the accumulator and index, overriding START.
REQ-027 RESET mid-conversion SHALL abort with no DONE pulse; the next START SHALL convert normally.

Verification
REQ-028 Digits 1,2,3,4,5 (BCD4..BCD0), START 1 cycle -> DONE 6 cycles later, BIN=0x03039, ERR=0.
REQ-029 Digits 9,9,9,9,9 -> BIN=0x1869F; digits 0,0,0,0,0 -> BIN=0, ERR=0.
REQ-030 BCD2=0xA, others 0 -> DONE at same latency, ERR=1, BIN=0; next valid conversion clears ERR.
REQ-031 Change BCD inputs and pulse START during CONV -> result matches captured digits, single DONE, no restart.
REQ-032 RESET asserted 2 cycles into CONV -> BUSY=0, BIN=0, no DONE; subsequent 0,1,0,2,3 -> BIN=1023 (0x003FF).
REQ-033 START held high for 20 cycles -> DONE pulses every 7 cycles, each exactly 1 cycle wide.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential 5-digit BCD to 17-bit binary converter.
// One digit per clock (most significant first), fixed 6-cycle latency from START to DONE.
module bcd2bin_seq (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        START,
    input  logic [3:0]  BCD0,
    input  logic [3:0]  BCD1,
    input  logic [3:0]  BCD2,
    input  logic [3:0]  BCD3,
    input  logic [3:0]  BCD4,
    output logic [16:0] BIN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [19:0] digits;
    logic [16:0] acc;
    logic [2:0]  index;
    logic        invalid;

    logic [3:0]  digit;
    logic [16:0] acc_next;

    // Current digit, selected from the captured copy so input changes after capture are ignored.
    always_comb begin
        digit = 4'd0;
        case (index)
            3'd0:    digit = digits[3:0];
            3'd1:    digit = digits[7:4];
            3'd2:    digit = digits[11:8];
            3'd3:    digit = digits[15:12];
            3'd4:    digit = digits[19:16];
            default: digit = 4'd0;
        endcase
        acc_next = (acc << 3) + (acc << 1) + {13'd0, digit};
    end

    assign BUSY      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state   <= IDLE;
            digits  <= 20'd0;
            acc     <= 17'd0;
            index   <= 3'd0;
            invalid <= 1'b0;
            BIN     <= 17'd0;
            ERR     <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        digits  <= {BCD4, BCD3, BCD2, BCD1, BCD0};
                        acc     <= 17'd0;
                        index   <= 3'd4;
                        invalid <= (BCD4 > 4'd9) || (BCD3 > 4'd9) || (BCD2 > 4'd9) ||
                                   (BCD1 > 4'd9) || (BCD0 > 4'd9);
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    if (index == 3'd0) begin
                        // BIN/ERR only change here, so they hold steady through the next conversion.
                        BIN   <= invalid ? 17'd0 : acc_next;
                        ERR   <= invalid;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        index <= index - 3'd1;
                    end
                end
                FIN: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: driver pushes expected {done_edge, err, bin} into a queue,
// a negedge monitor pops and compares whenever DONE is seen.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  bcd0 = 4'd0, bcd1 = 4'd0, bcd2 = 4'd0, bcd3 = 4'd0, bcd4 = 4'd0;
    logic [16:0] bin;
    logic        busy, done, err;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;

    logic [31:0] cyc = 32'd0;
    logic        rst_seen = 1'b1;
    logic        prev_done = 1'b0;
    logic [16:0] hold_bin = 17'd0;
    logic        hold_err = 1'b0;

    // {done_edge[31:0], err, bin[16:0]}
    logic [49:0] exp_q[$];

    bcd2bin_seq dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .START    (start),
        .BCD0     (bcd0),
        .BCD1     (bcd1),
        .BCD2     (bcd2),
        .BCD3     (bcd3),
        .BCD4     (bcd4),
        .BIN      (bin),
        .BUSY     (busy),
        .DONE     (done),
        .ERR      (err),
        .fsm_state(fsm_state)
    );

    // Clock and edge counter: after rising edge n, cyc == n.
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc      <= cyc + 32'd1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: plain decimal weighting; any digit above 9 makes the result 0 with ERR.
    function automatic logic [17:0] model(input logic [19:0] d);
        int  val;
        logic bad;
        val = 0;
        bad = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            int dig;
            dig = int'(d[i*4 +: 4]);
            if (dig > 9) bad = 1'b1;
            val = val * 10 + dig;
        end
        if (bad) return {1'b1, 17'd0};
        return {1'b0, 17'(val)};
    endfunction

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    function automatic logic [19:0] rand_digits();
        return {rand_digit(), rand_digit(), rand_digit(), rand_digit(), rand_digit()};
    endfunction

    task automatic drive_digits(input logic [19:0] d);
        {bcd4, bcd3, bcd2, bcd1, bcd0} = d;
    endtask

    // Returns just after a rising edge (+2) with the DUT idle.
    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (!busy) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    // START is sampled at edge cyc+1, DONE is expected after edge cyc+6.
    task automatic push_expect(input logic [19:0] d, input logic [31:0] done_edge);
        exp_q.push_back({done_edge, model(d)});
    endtask

    task automatic start_conv(input logic [19:0] d);
        wait_idle();
        drive_digits(d);
        start = 1'b1;
        push_expect(d, cyc + 32'd6);
        @(posedge clk);
        #2;
        start = 1'b0;
        drive_digits(rand_digits());
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_seen) begin
            hold_bin = 17'd0;
            hold_err = 1'b0;
        end else if (done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [49:0] e;
                e = exp_q.pop_front();
                check("bin", {15'd0, bin}, {15'd0, e[16:0]});
                check("err", {31'd0, err}, {31'd0, e[17]});
                check("done_edge", cyc, e[49:18]);
                check("busy_in_fin", {31'd0, busy}, 32'd1);
                hold_bin = e[16:0];
                hold_err = e[17];
            end
        end else begin
            check("bin_hold", {15'd0, bin}, {15'd0, hold_bin});
            check("err_hold", {31'd0, err}, {31'd0, hold_err});
        end
        prev_done = done;
    end

    initial begin
        logic [19:0] d;
        logic [31:0] base;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bin", {15'd0, bin}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Directed values, including an invalid digit and the valid conversion that clears ERR.
        start_conv({4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
        start_conv({4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
        start_conv({4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        start_conv({4'd0, 4'd0, 4'hA, 4'd0, 4'd0});
        start_conv({4'd0, 4'd0, 4'd0, 4'd4, 4'd2});
        start_conv({4'hF, 4'd0, 4'd0, 4'd0, 4'd0});
        start_conv({4'd0, 4'd0, 4'd0, 4'd0, 4'hB});

        // START pulses while converting (CONV and FIN) with new digits must be ignored.
        start_conv({4'd3, 4'd1, 4'd4, 4'd1, 4'd5});
        @(posedge clk);
        #2;
        drive_digits(rand_digits());
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("busy_before_fin_pulse", {31'd0, busy}, 32'd1);
        drive_digits(rand_digits());
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;

        // Reset two cycles into CONV aborts without DONE.
        start_conv({4'd9, 4'd8, 4'd7, 4'd6, 4'd5});
        @(posedge clk);
        #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bin", {15'd0, bin}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        start_conv({4'd0, 4'd1, 4'd0, 4'd2, 4'd3});

        // START held high for 20 cycles: captures every 7 edges.
        wait_idle();
        d = rand_digits();
        drive_digits(d);
        start = 1'b1;
        base = cyc;
        push_expect(d, base + 32'd6);
        push_expect(d, base + 32'd13);
        push_expect(d, base + 32'd20);
        repeat (20) @(posedge clk);
        #2;
        start = 1'b0;

        // Randomized conversions.
        for (int i = 0; i < 30; i++) begin
            start_conv(rand_digits());
        end

        // Drain outstanding expectations.
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
